// File: rtl/seq_divider.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seq_divider : iterative restoring divider, one quotient bit per clock.   |
// | Optional signed support via `DIV_SIGNED_EN.            Revision: 1.0     |
// +--------------------------------------------------------------------------+
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] din_a,
    input  logic [WIDTH-1:0] din_b,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic             vout
);

    localparam int              c_CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);
    localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_FIX  = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [c_CW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;     // dividend shifts out while quotient shifts in
    logic [WIDTH-1:0] prem_q, prem_d;
    logic [WIDTH:0]   dvs_q, dvs_d;
    logic [WIDTH-1:0] araw_q, araw_d;
    logic             dzp_q, dzp_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_qfix;
    logic [WIDTH-1:0] w_rfix;
    logic             unused_ok;

    assign w_shift = {prem_q, dvd_q[WIDTH-1]};
    assign w_diff  = {1'b0, w_shift} - {1'b0, dvs_q};
    assign w_ge    = ~w_diff[WIDTH+1];

`ifdef DIV_SIGNED_EN
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             ovfp_q, ovfp_d;
    logic             vout_q, vout_d;
    logic             w_aneg, w_bneg, w_ovf;
    logic [WIDTH:0]   w_amag, w_bmag;

    // Magnitudes are one bit wider so that the most negative value stays exact.
    assign w_aneg  = sign & din_a[WIDTH-1];
    assign w_bneg  = sign & din_b[WIDTH-1];
    assign w_amag  = w_aneg ? -{din_a[WIDTH-1], din_a} : {1'b0, din_a};
    assign w_bmag  = w_bneg ? -{din_b[WIDTH-1], din_b} : {1'b0, din_b};
    assign w_ovf   = sign & (din_a == {1'b1, {(WIDTH-1){1'b0}}}) & (&din_b);
    assign w_qfix  = qneg_q ? -dvd_q : dvd_q;
    assign w_rfix  = rneg_q ? -prem_q : prem_q;
    assign unused_ok = w_diff[WIDTH] ^ w_amag[WIDTH];
    assign vout    = vout_q;
`else
    assign w_qfix  = dvd_q;
    assign w_rfix  = prem_q;
    assign unused_ok = w_diff[WIDTH] ^ sign;
    assign vout    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        prem_d  = prem_q;
        dvs_d   = dvs_q;
        araw_d  = araw_q;
        dzp_d   = dzp_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dz_d    = dz_q;
`ifdef DIV_SIGNED_EN
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        ovfp_d  = ovfp_q;
        vout_d  = vout_q;
`endif
        case (state_q)
            c_IDLE: begin
                if (start) begin
                    state_d = c_CALC;
                    cnt_d   = '0;
                    prem_d  = '0;
                    araw_d  = din_a;
                    dzp_d   = (din_b == '0);
                    busy_d  = 1'b1;
                    dz_d    = 1'b0;
`ifdef DIV_SIGNED_EN
                    dvd_d   = w_amag[WIDTH-1:0];
                    dvs_d   = w_bmag;
                    qneg_d  = w_aneg ^ w_bneg;
                    rneg_d  = w_aneg;
                    ovfp_d  = w_ovf;
                    vout_d  = 1'b0;
`else
                    dvd_d   = din_a;
                    dvs_d   = {1'b0, din_b};
`endif
                end
            end
            c_CALC: begin
                prem_d = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
                dvd_d  = {dvd_q[WIDTH-2:0], w_ge};
                cnt_d  = cnt_q + c_ONE;
                if (cnt_q == c_LAST) begin
                    state_d = c_FIX;
                end
            end
            c_FIX: begin
                state_d = c_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (dzp_q) begin
                    quot_d = '1;
                    rem_d  = araw_q;
                    dz_d   = 1'b1;
                end
`ifdef DIV_SIGNED_EN
                else if (ovfp_q) begin
                    quot_d = {1'b1, {(WIDTH-1){1'b0}}};
                    rem_d  = '0;
                    vout_d = 1'b1;
                end
`endif
                else begin
                    quot_d = w_qfix;
                    rem_d  = w_rfix;
                end
            end
            c_DONE: begin
                state_d = c_IDLE;
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= c_IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            prem_q  <= '0;
            dvs_q   <= '0;
            araw_q  <= '0;
            dzp_q   <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            prem_q  <= prem_d;
            dvs_q   <= dvs_d;
            araw_q  <= araw_d;
            dzp_q   <= dzp_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

`ifdef DIV_SIGNED_EN
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            ovfp_q <= 1'b0;
            vout_q <= 1'b0;
        end else begin
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
            ovfp_q <= ovfp_d;
            vout_q <= vout_d;
        end
    end
`endif

    assign quot = quot_q;
    assign rem  = rem_q;
    assign busy = busy_q;
    assign done = done_q;
    assign dz   = dz_q;

endmodule
`default_nettype wire
